// File: rtl/instr_encoder_loader.sv
// Purpose : encodes RV32/RV64 instruction fields into 32-bit words and writes them to instruction memory.
// Latency : a word accepted at cycle N is written (mem_we) at cycle N+1; one word per two cycles.
// Backpres: in_ready is high only while waiting for a word; it drops during the write and after the session ends.
// Optional: define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format (err_imm).
module instr_encoder_loader #(
  parameter int MEM_SIZE   = 512,
  parameter int MAX_WORDS  = MEM_SIZE,
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_opcode,
  output logic                  err_imm,
  output logic                  ovf
);

  typedef enum logic [6:0] {
    OP_I_TYPE_LOAD  = 7'h03,
    OP_I_TYPE_ARITH = 7'h13,
    OP_S_TYPE       = 7'h23,
    OP_R_TYPE       = 7'h33,
    OP_RV64_TYPE    = 7'h3B,
    OP_B_TYPE       = 7'h63,
    OP_J_TYPE       = 7'h6F
  } opcode_e;

  typedef logic [4:0] reg_addr_t;

  localparam logic [2:0]  F3_SLL     = 3'b001;
  localparam logic [2:0]  F3_SRL_SRA = 3'b101;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [XLEN-1:0]       r_mem_wdata;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_last;
  logic                  r_err_opcode;
  logic                  r_err_imm;
  logic                  r_ovf;

  reg_addr_t             w_rd;
  reg_addr_t             w_rs1;
  reg_addr_t             w_rs2;
  logic [31:0]           w_enc;
  logic                  w_op_bad;
  logic                  w_imm_bad;
  logic                  w_is_shift;
  logic [ADDR_WIDTH:0]   w_count_inc;

  assign w_rd        = in_rd;
  assign w_rs1       = in_rs1;
  assign w_rs2       = in_rs2;
  assign w_is_shift  = (in_opcode == OP_I_TYPE_ARITH) &&
                       ((in_funct3 == F3_SLL) || (in_funct3 == F3_SRL_SRA));
  assign w_count_inc = r_count + (ADDR_WIDTH+1)'(1);

  // Format selection: pack the fields of the presented instruction into one 32-bit word
  always_comb begin
    w_enc    = NOP_WORD;
    w_op_bad = 1'b0;
    case (in_opcode)
      OP_R_TYPE, OP_RV64_TYPE:
        w_enc = {in_funct7, w_rs2, w_rs1, in_funct3, w_rd, in_opcode};
      OP_I_TYPE_LOAD, OP_I_TYPE_ARITH: begin
        if (w_is_shift)
          w_enc = {in_funct7, in_imm[4:0], w_rs1, in_funct3, w_rd, in_opcode};
        else
          w_enc = {in_imm[11:0], w_rs1, in_funct3, w_rd, in_opcode};
      end
      OP_S_TYPE:
        w_enc = {in_imm[11:5], w_rs2, w_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_B_TYPE:
        w_enc = {in_imm[12], in_imm[10:5], w_rs2, w_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], in_opcode};
      OP_J_TYPE:
        w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], w_rd, in_opcode};
      default: begin
        w_enc    = NOP_WORD;
        w_op_bad = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  localparam logic signed [XLEN-1:0] IMM12_MIN = XLEN'(-2048);
  localparam logic signed [XLEN-1:0] IMM12_MAX = XLEN'(2047);
  localparam logic signed [XLEN-1:0] SHAMT_MIN = XLEN'(0);
  localparam logic signed [XLEN-1:0] SHAMT_MAX = XLEN'(31);
  localparam logic signed [XLEN-1:0] BOFF_MIN  = XLEN'(-4096);
  localparam logic signed [XLEN-1:0] BOFF_MAX  = XLEN'(4094);
  localparam logic signed [XLEN-1:0] JOFF_MIN  = XLEN'(-1048576);
  localparam logic signed [XLEN-1:0] JOFF_MAX  = XLEN'(1048574);

  logic signed [XLEN-1:0] w_simm;
  assign w_simm = in_imm;

  // Immediate range check: flag values the chosen format cannot represent (the word is still truncated and written)
  always_comb begin
    w_imm_bad = 1'b0;
    case (in_opcode)
      OP_I_TYPE_LOAD, OP_I_TYPE_ARITH: begin
        if (w_is_shift)
          w_imm_bad = (w_simm < SHAMT_MIN) || (w_simm > SHAMT_MAX);
        else
          w_imm_bad = (w_simm < IMM12_MIN) || (w_simm > IMM12_MAX);
      end
      OP_S_TYPE:
        w_imm_bad = (w_simm < IMM12_MIN) || (w_simm > IMM12_MAX);
      OP_B_TYPE:
        w_imm_bad = (w_simm < BOFF_MIN) || (w_simm > BOFF_MAX) || in_imm[0];
      OP_J_TYPE:
        w_imm_bad = (w_simm < JOFF_MIN) || (w_simm > JOFF_MAX) || in_imm[0];
      default:
        w_imm_bad = 1'b0;
    endcase
  end
`else
  // Without the range check the upper immediate bits are simply dropped by the formats
  logic w_unused_imm;
  assign w_unused_imm = ^in_imm[XLEN-1:21];
  assign w_imm_bad    = 1'b0;
`endif

  // Session FSM: start -> accept one word -> write it -> repeat until last or word limit -> done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_done       <= 1'b0;
      r_waddr      <= '0;
      r_count      <= '0;
      r_last       <= 1'b0;
      r_err_opcode <= 1'b0;
      r_err_imm    <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_ACCEPT;
            r_in_ready   <= 1'b1;
            r_waddr      <= '0;
            r_count      <= '0;
            r_err_opcode <= 1'b0;
            r_err_imm    <= 1'b0;
            r_ovf        <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCEPT: begin
          if (in_valid && r_in_ready) begin
            r_state     <= ST_WRITE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_waddr;
            r_mem_wdata <= XLEN'(w_enc);
            r_last      <= in_last;
            if (w_op_bad)  r_err_opcode <= 1'b1;
            if (w_imm_bad) r_err_imm    <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_waddr <= r_waddr + ADDR_WIDTH'(1);
          r_count <= w_count_inc;
          if (r_last || (w_count_inc == MAX_CNT)) begin
            // Hitting the word limit without a last marker is an overflow; the session closes either way
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            if (!r_last) r_ovf <= 1'b1;
          end else begin
            r_state    <= ST_ACCEPT;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign done       = r_done;
  assign count      = r_count;
  assign err_opcode = r_err_opcode;
  assign err_imm    = r_err_imm;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Purpose : directed self-checking bench for instr_encoder_loader (word limit 4).
// Latency : checks mem_we one cycle after accept and done one cycle after the final write.
// Backpres: sends wait on in_ready with a bounded cycle budget.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic [9:0]  count;
  logic        err_opcode, err_imm, ovf;

  int total = 0;
  int bad   = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

`ifdef IMM_RANGE_CHECK_EN
  localparam logic [31:0] EXP_ERR_IMM = 32'd1;
`else
  localparam logic [31:0] EXP_ERR_IMM = 32'd0;
`endif

  instr_encoder_loader #(.MAX_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .count(count),
    .err_opcode(err_opcode), .err_imm(err_imm), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Write log sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back({23'b0, mem_addr});
      wd.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one instruction once in_ready is seen; returns on the negedge of its write cycle
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic last);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready === 1'b1) begin
      in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      check("we_latency", {31'b0, mem_we}, 32'd1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic check_log(input int n, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check("write_cnt", wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check("waddr", wa[i], i);
      check("wdata", wd[i], e[i]);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_mem_we",   {31'b0, mem_we}, 32'd0);
    check("rst_done",     {31'b0, done}, 32'd0);
    check("rst_count",    {22'b0, count}, 32'd0);
    check("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
    check("rst_wdata",    mem_wdata, 32'd0);
    check("rst_errs",     {29'b0, err_opcode, err_imm, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2 as a one-word session
    clear_log();
    start_session();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    check("r_addr",  {23'b0, mem_addr}, 32'd0);
    check("r_wdata", mem_wdata, 32'h002081B3);
    @(negedge clk);
    check("r_done",  {31'b0, done}, 32'd1);
    check("r_count", {22'b0, count}, 32'd1);
    @(negedge clk);
    check("r_done_pulse", {31'b0, done}, 32'd0);
    check("r_idle_ready", {31'b0, in_ready}, 32'd0);
    check_log(1, 32'h002081B3, 0, 0, 0);

    // sw x5,-4(x2); beq x0,x0,-8; jal x1,2048
    clear_log();
    start_session();
    send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b0);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
    wait_done();
    check("sbj_count", {22'b0, count}, 32'd3);
    check("sbj_errs",  {29'b0, err_opcode, err_imm, ovf}, 32'd0);
    check_log(3, 32'hFE512E23, 32'hFE000CE3, 32'h001000EF, 0);

    // unsupported opcode (LUI) writes NOP and raises a sticky error
    clear_log();
    start_session();
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
    wait_done();
    check("bad_op_err", {31'b0, err_opcode}, 32'd1);
    check("bad_op_cnt", {22'b0, count}, 32'd1);
    check_log(1, 32'h0000_0013, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("bad_op_sticky", {31'b0, err_opcode}, 32'd1);

    // next start clears the flag; addi x1,x0,3000 overflows the 12-bit field
    clear_log();
    start_session();
    check("err_op_clr", {31'b0, err_opcode}, 32'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3000, 1'b1);
    wait_done();
    check("addi_err_imm", {31'b0, err_imm}, EXP_ERR_IMM);
    check_log(1, 32'hBB800093, 0, 0, 0);

    // srai x3,x4,7; lw x6,8(x7); addw x10,x11,x12
    clear_log();
    start_session();
    check("err_imm_clr", {31'b0, err_imm}, 32'd0);
    send(7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7, 1'b0);
    send(7'h03, 5'd6, 5'd7, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0);
    send(7'h3B, 5'd10, 5'd11, 5'd12, 3'd0, 7'd0, 32'd0, 1'b1);
    wait_done();
    check("ils_errs", {29'b0, err_opcode, err_imm, ovf}, 32'd0);
    check_log(3, 32'h40725193, 32'h0083A303, 32'h00C5853B, 0);

    // word limit: four words without last, then a fifth is offered
    clear_log();
    start_session();
    for (int k = 1; k <= 4; k++)
      send(7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, k, 1'b0);
    wait_done();
    check("ovf_flag",  {31'b0, ovf}, 32'd1);
    check("ovf_count", {22'b0, count}, 32'd4);
    check_log(4, 32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213);
    in_valid = 1'b1; in_opcode = 7'h13; in_rd = 5'd5; in_imm = 32'd5;
    for (int k = 0; k < 5; k++) begin
      check("fifth_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("fifth_nowrite", wa.size(), 32'd4);
    check("ovf_sticky", {31'b0, ovf}, 32'd1);

    // reset in the middle of a session, asserted during a write cycle
    clear_log();
    start_session();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3000, 1'b0);
    send(7'h0B, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    check("pre_rst_addr", {23'b0, mem_addr}, 32'd1);
    check("pre_rst_err",  {31'b0, err_opcode}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_we",    {31'b0, mem_we}, 32'd0);
    check("mid_rst_outs",  {28'b0, in_ready, done, err_opcode, err_imm}, 32'd0);
    check("mid_rst_ovf",   {31'b0, ovf}, 32'd0);
    check("mid_rst_count", {22'b0, count}, 32'd0);
    check("mid_rst_addr",  {23'b0, mem_addr}, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abandon_writes", wa.size(), 32'd2);
    check("abandon_ready", {31'b0, in_ready}, 32'd0);
    clear_log();
    start_session();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    wait_done();
    check("restart_count", {22'b0, count}, 32'd1);
    check_log(1, 32'h002081B3, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
